// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared definitions for the LDPC shift-schedule controller.
//   state_t      : controller states (IDLE, FETCH, EVAL, DONE)
//   PH_GATHER    : phase 0, VTC->C gather pass
//   PH_SCATTER   : phase 1, CTV->V scatter pass
//   null_bit_pos : bit index of the null flag in a {null, shift} ROM word
//   idx_w        : index width for a count of n items (at least 1 bit)
package ldpc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PH_GATHER  = 1'b0;
  localparam logic PH_SCATTER = 1'b1;

  // The null flag sits directly above the shift field.
  function automatic int null_bit_pos(input int data_w);
    return data_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ldpc_rc_counter.sv
// ldpc_rc_counter: col / phase / row / iteration index walker.
// Order of traversal: col fastest, then phase (gather, scatter), then row,
// then iteration.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : zero all indices (start of a run)
//   advance       : step to the next block position
//   col, phase    : current column and pass
//   row, iter     : current row and completed-iteration count
//   iter_end      : advance is consuming the last block of an iteration
module ldpc_rc_counter
  import ldpc_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 8,
  parameter int ITER_W = 4,
  localparam int CW    = idx_w(COLS),
  localparam int RW    = idx_w(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [CW-1:0]     col,
  output logic              phase,
  output logic [RW-1:0]     row,
  output logic [ITER_W-1:0] iter,
  output logic              iter_end
);

  logic col_last;
  logic row_last;

  assign col_last = (col == CW'(COLS - 1));
  assign row_last = (row == RW'(ROWS - 1));
  assign iter_end = advance && col_last && (phase == PH_SCATTER) && row_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col   <= '0;
      phase <= PH_GATHER;
      row   <= '0;
      iter  <= '0;
    end else if (clear) begin
      col   <= '0;
      phase <= PH_GATHER;
      row   <= '0;
      iter  <= '0;
    end else if (advance) begin
      if (!col_last) begin
        col <= col + 1'b1;
      end else begin
        col <= '0;
        if (phase == PH_GATHER) begin
          phase <= PH_SCATTER;
        end else begin
          phase <= PH_GATHER;
          if (row_last) begin
            row  <= '0;
            iter <= iter + 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ldpc_shift_sched.sv
// ldpc_shift_sched: schedule controller for the layered LDPC cyclic-shift
// network. Walks the base matrix (gather then scatter pass per row), reads
// each block's shift from an external registered ROM, skips null blocks and
// issues shift commands under a valid/ready handshake.
// Optional feature: define LDPC_SCHED_EARLY_STOP_EN to let stop_early end
// decoding at an iteration boundary before MAX_ITER.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin decoding (sampled in IDLE only)
//   stop_early          : syndrome-zero flag (used only with the macro)
//   rom_addr / rom_data : base-matrix ROM, data valid one cycle after address
//   sh_valid / sh_ready : command handshake
//   sh_shift, sh_col, sh_row, sh_phase : command fields
//   busy, done          : run status, one-cycle completion pulse
//   iter_cnt            : completed iterations
//   shift_err           : sticky, a non-null entry had shift >= D
module ldpc_shift_sched
  import ldpc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int D        = 5,
  parameter int ROWS     = 4,
  parameter int COLS     = 8,
  parameter int MAX_ITER = 10,
  parameter int ITER_W   = 4,
  parameter int AW       = 5,
  localparam int CW      = idx_w(COLS),
  localparam int RW      = idx_w(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop_early,
  output logic [AW-1:0]     rom_addr,
  input  logic [DATA_W:0]   rom_data,
  output logic              sh_valid,
  input  logic              sh_ready,
  output logic [DATA_W-1:0] sh_shift,
  output logic [CW-1:0]     sh_col,
  output logic [RW-1:0]     sh_row,
  output logic              sh_phase,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              shift_err
);

  localparam int NB = null_bit_pos(DATA_W);

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       col;
  logic                phase;
  logic [RW-1:0]       row;
  logic [ITER_W-1:0]   iter;
  logic                iter_end;
  logic                advance;
  logic                clear;
  logic                entry_null;
  logic [DATA_W-1:0]   entry_shift;
  logic                shift_bad;
  logic                last_iter;
  logic                early_stop;

  // Out-of-range shifts are folded back into [0, D): one subtraction covers
  // values below 2D, anything larger saturates to D-1.
  function automatic logic [DATA_W-1:0] reduce_shift(input logic [DATA_W-1:0] s);
    int sv;
    sv = int'(s);
    if (sv < D)          return s;
    else if (sv < 2 * D) return DATA_W'(sv - D);
    else                 return DATA_W'(D - 1);
  endfunction

  ldpc_rc_counter #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ITER_W (ITER_W)
  ) u_walker (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .advance  (advance),
    .col      (col),
    .phase    (phase),
    .row      (row),
    .iter     (iter),
    .iter_end (iter_end)
  );

  assign entry_null  = rom_data[NB];
  assign entry_shift = rom_data[DATA_W-1:0];
  assign shift_bad   = (int'(entry_shift) >= D);
  assign last_iter   = ((int'(iter) + 1) == MAX_ITER);

`ifdef LDPC_SCHED_EARLY_STOP_EN
  assign early_stop = stop_early;
`else
  logic unused_stop_early;
  assign unused_stop_early = stop_early;
  assign early_stop        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: state_next = EVAL;
      EVAL: begin
        if (entry_null || sh_ready) begin
          advance = 1'b1;
          if (iter_end && (last_iter || early_stop)) state_next = DONE;
          else                                       state_next = FETCH;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_err <= 1'b0;
    end else if (clear) begin
      shift_err <= 1'b0;
    end else if (state == EVAL && !entry_null && shift_bad) begin
      shift_err <= 1'b1;
    end
  end

  // Address comes straight from the index registers, which only change on
  // advance, so it is stable through FETCH and any EVAL stall.
  assign rom_addr = AW'(int'(row) * COLS + int'(col));

  // Command fields derive from the ROM word and index registers, both of
  // which are frozen while a command waits for sh_ready.
  assign sh_valid = (state == EVAL) && !entry_null;
  assign sh_shift = sh_valid ? reduce_shift(entry_shift) : '0;
  assign sh_col   = col;
  assign sh_row   = row;
  assign sh_phase = phase;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign iter_cnt = iter;

endmodule

// File: doc/ldpc_shift_sched.md
# ldpc_shift_sched

Schedule controller for the layered LDPC decoder's cyclic-shift network. It walks the base matrix row by row and reads each block's shift from an external base-matrix ROM, skipping null blocks. For each non-null block it issues a shift command (shift, column, row, phase) to the cyclic-shift datapath under a valid/ready handshake. It runs a gather pass (VTC→C) then a scatter pass (CTV→V) per row and repeats for up to MAX_ITER iterations.

## Interface
- DATA_W, 8, shift field width; matches the cyclic-shift datapath `shift` port
- D, 5, lifting size; every legal shift is < D
- ROWS, 4, base-matrix rows
- COLS, 8, base-matrix columns
- MAX_ITER, 10, maximum decoding iterations (≥1)
- ITER_W, 4, iteration counter width
- AW, 5, ROM address width, ≥ clog2(ROWS*COLS)

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin decoding; sampled only in IDLE
- stop_early  in  1  syndrome-zero flag from decoder (used only with macro)
- rom_addr  out  AW  base-matrix address = row*COLS+col
- rom_data  in  DATA_W+1  {null, shift}; valid 1 cycle after rom_addr; null=1 means zero block
- sh_valid  out  1  shift command valid
- sh_ready  in  1  datapath accepts command
- sh_shift  out  DATA_W  shift value to datapath
- sh_col  out  clog2(COLS)  column index
- sh_row  out  clog2(ROWS)  row index
- sh_phase  out  1  0=gather (VTC→C), 1=scatter (CTV→V)
- busy  out  1  high from the cycle after start until DONE exits
- done  out  1  one-cycle pulse at end of decoding
- iter_cnt  out  ITER_W  completed iterations
- shift_err  out  1  sticky: non-null entry with shift ≥ D seen

## Operation
- States: IDLE, FETCH, EVAL, DONE.
- IDLE: busy=0, sh_valid=0. start=1 clears row, col, phase and iter_cnt to 0, clears shift_err, and moves to FETCH.
- FETCH: rom_addr = row*COLS+col (registered). One wait cycle, then EVAL.
- EVAL (rom_data valid):
  - null=1: no command; advance, go to FETCH.
  - null=0: sh_valid=1 with sh_shift=rom_data shift field. Hold all sh_* stable until sh_valid&&sh_ready, then advance and go to FETCH.
  - shift ≥ D: set shift_err. The command is still issued with the shift reduced by repeated subtraction of D (single compare/subtract suffices if shift < 2D; larger values are clamped to D-1).
- Advance:
  - col<COLS-1: col+1.
  - Otherwise col=0, and:
    - phase=0 → phase=1.
    - phase=1 → phase=0 and next row. At row=ROWS-1 the iteration ends: iter_cnt+1, row=0.
- Iteration end: go to DONE if the new iter_cnt==MAX_ITER (or early stop, see Configuration); otherwise go to FETCH.
- DONE: done=1, busy=1 for one cycle, then IDLE.
- A row with all null entries produces no handshakes but still costs 2*COLS*2 cycles.
- start while busy is ignored.
- sh_ready while sh_valid=0 is ignored.

## Timing
- Reset: state=IDLE; rom_addr=0, sh_valid=0, sh_shift=0, sh_col=0, sh_row=0, sh_phase=0, busy=0, done=0, iter_cnt=0, shift_err=0.
- Reset asserted mid-run aborts immediately; the in-flight command is dropped.
- start at cycle t: busy=1 and FETCH at t+1; first EVAL at t+2.
- Minimum 2 cycles per block (FETCH+EVAL), whether null or accepted with zero stall.
- Each cycle of sh_ready=0 in EVAL adds one stall cycle.
- Total with no stalls: MAX_ITER*ROWS*2*COLS*2 cycles + 2 (start, DONE).
- done pulses in the cycle after the final advance; busy falls with done.

## Configuration
- LDPC_SCHED_EARLY_STOP_EN defined:
  - stop_early is sampled in the cycle an iteration ends.
  - If high, go to DONE with the incremented iter_cnt even if below MAX_ITER.
- Undefined: stop_early is ignored; every run completes exactly MAX_ITER iterations.

## Structure
- Shared package ldpc_pkg holds:
  - state enum (IDLE, FETCH, EVAL, DONE)
  - phase constants PH_GATHER=0, PH_SCATTER=1
  - null-bit position constant in rom_data
- Natural sub-module: ldpc_rc_counter, the col/phase/row/iteration index walker. Interface: advance input; col, phase, row, iter, iter_end outputs.

## Test plan
- Defaults, ROWS=2, COLS=3, MAX_ITER=1, all entries non-null with shift=col+row, sh_ready=1 → 12 commands in order r0g(0,1,2), r0s(0,1,2), r1g(1,2,3), r1s(1,2,3); done at cycle 26 after start; iter_cnt=1.
- Entry (0,1) null → that column is skipped in both phases; 10 commands; total cycle count unchanged.
- sh_ready held low 5 cycles on the first command → sh_* stable throughout; completion delayed by exactly 5 cycles.
- Entry with shift=7, D=5 → sh_shift=2, shift_err=1 until the next start.
- With LDPC_SCHED_EARLY_STOP_EN, MAX_ITER=10, stop_early=1 at the end of iteration 3 → done with iter_cnt=3. Without the macro → iter_cnt=10.
- rst low mid-scatter, then start again → all outputs at reset values immediately; the next run starts from row 0, col 0, phase 0.
